// File: rtl/m107_irq_gen_if.sv
// CPU register-write bus into the interrupt generator.
// Latency: n/a (signal bundle only).
// Backpressure: none; a write is a single-cycle strobe that is always accepted.
//
// Signals:
//   cs   - chip select for the interrupt generator
//   wr   - write strobe, one clk wide, qualified by cs
//   addr - register select (0 raster low byte, 1 raster commit, 2 enable, 3 clear)
//   din  - write data
interface m107_irq_gen_if;
    logic       cs;
    logic       wr;
    logic [1:0] addr;
    logic [7:0] din;

    // CPU side drives the bus.
    modport master (
        output cs,
        output wr,
        output addr,
        output din
    );

    // Interrupt generator samples the bus.
    modport slave (
        input cs,
        input wr,
        input addr,
        input din
    );
endinterface

// File: rtl/m107_irq_gen.sv
// Interrupt request generator: vblank / sprite DMA / raster pulses plus a sound-reply level.
// Latency: edge sources raise intp one clk edge after the trigger; intp[3] is combinational.
// Backpressure: none; CPU writes always land in one cycle, triggers are never queued.
//
// Ports:
//   clk, reset     - system clock, asynchronous active-high reset
//   ce_pix         - pixel enable qualifying vblank / raster sampling
//   hcount, vcount - current beam position
//   vblank         - vertical blank level
//   cpu            - register write bus (cs, wr, addr, din), slave side
//   dma_done       - sprite DMA completion level
//   snd_reply      - sound CPU reply-latch pending level
//   intp           - interrupt lines: [0] vblank, [1] DMA, [2] raster, [3] sound, [7:4] zero
module m107_irq_gen #(
    parameter int         PULSE_LEN   = 16,
    parameter logic [9:0] RASTER_HPOS = 10'd320
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ce_pix,
    input  logic [9:0]           hcount,
    input  logic [8:0]           vcount,
    input  logic                 vblank,
    m107_irq_gen_if.slave        cpu,
    input  logic                 dma_done,
    input  logic                 snd_reply,
    output logic [7:0]           intp
);

    localparam logic [7:0] PULSE_LD = 8'(PULSE_LEN);

    localparam logic [1:0] ADDR_RASTER_LO = 2'd0;
    localparam logic [1:0] ADDR_RASTER_HI = 2'd1;
    localparam logic [1:0] ADDR_ENABLE    = 2'd2;
    localparam logic [1:0] ADDR_CLEAR     = 2'd3;

    // ------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------
    logic       wr_en;
    logic [7:0] raster_lo;
    logic [8:0] raster_line;
    logic [3:0] enable;

    assign wr_en = cpu.cs & cpu.wr;

    // The low byte is only staged; the compare line changes atomically when
    // the high bit is written, so the compare never sees a half-updated line.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            raster_lo   <= 8'h00;
            raster_line <= 9'h000;
            enable      <= 4'h0;
        end else if (wr_en) begin
            case (cpu.addr)
                ADDR_RASTER_LO: raster_lo   <= cpu.din;
                ADDR_RASTER_HI: raster_line <= {cpu.din[0], raster_lo};
                ADDR_ENABLE:    enable      <= cpu.din[3:0];
                default:        ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Edge detection
    // ------------------------------------------------------------------
    // History registers run regardless of the enable bits, so turning a
    // source on while its level is already high does not fake an edge.
    // vblank history advances only on pixel-enable cycles; dma_done every clk.
    logic vblank_hist;
    logic dma_hist;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vblank_hist <= 1'b0;
            dma_hist    <= 1'b0;
        end else begin
            if (ce_pix) begin
                vblank_hist <= vblank;
            end
            dma_hist <= dma_done;
        end
    end

    logic [2:0] trig;

    always_comb begin
        trig    = 3'b000;
        trig[0] = ce_pix & vblank & ~vblank_hist;
        trig[1] = dma_done & ~dma_hist;
        trig[2] = ce_pix & (hcount == RASTER_HPOS) & (vcount == raster_line);
    end

    // ------------------------------------------------------------------
    // Pulse stretchers
    // ------------------------------------------------------------------
    // Priority per source: clear-all, then disable-by-write, then trigger
    // (reload, so a retrigger extends with no gap), then count down.
    logic       clear_all;
    logic [2:0] disable_wr;

    assign clear_all  = wr_en & (cpu.addr == ADDR_CLEAR);
    assign disable_wr = {3{wr_en & (cpu.addr == ADDR_ENABLE)}} & ~cpu.din[2:0];

    logic [7:0] pulse_cnt [3];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 3; i++) begin
                pulse_cnt[i] <= 8'h00;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (clear_all || disable_wr[i]) begin
                    pulse_cnt[i] <= 8'h00;
                end else if (trig[i] && enable[i]) begin
                    pulse_cnt[i] <= PULSE_LD;
                end else if (pulse_cnt[i] != 8'h00) begin
                    pulse_cnt[i] <= pulse_cnt[i] - 8'h01;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // enable and the counters are cleared asynchronously, so intp drops to
    // zero the moment reset asserts.
    always_comb begin
        intp    = 8'h00;
        intp[0] = (pulse_cnt[0] != 8'h00);
        intp[1] = (pulse_cnt[1] != 8'h00);
        intp[2] = (pulse_cnt[2] != 8'h00);
        intp[3] = snd_reply & enable[3];
    end

endmodule

// File: tb/tb_m107_irq_gen.sv
// Directed self-checking bench for the interrupt generator.
// Latency: n/a.
// Backpressure: n/a.
module tb_m107_irq_gen;

    logic       clk;
    logic       reset;
    logic       ce_pix;
    logic [9:0] hcount;
    logic [8:0] vcount;
    logic       vblank;
    logic       dma_done;
    logic       snd_reply;
    logic [7:0] intp;

    int tests;
    int fails;

    m107_irq_gen_if bus();

    m107_irq_gen #(
        .PULSE_LEN   (16),
        .RASTER_HPOS (10'd320)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .ce_pix    (ce_pix),
        .hcount    (hcount),
        .vcount    (vcount),
        .vblank    (vblank),
        .cpu       (bus),
        .dma_done  (dma_done),
        .snd_reply (snd_reply),
        .intp      (intp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clk and settle past the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cpu_write(input logic [1:0] a, input logic [7:0] d);
        bus.cs   = 1'b1;
        bus.wr   = 1'b1;
        bus.addr = a;
        bus.din  = d;
        tick();
        bus.cs   = 1'b0;
        bus.wr   = 1'b0;
    endtask

    // Count consecutive high samples of intp[idx], starting at the current sample.
    task automatic measure(input int idx, output int len);
        len = 0;
        while (intp[idx] && len < 100) begin
            len++;
            tick();
        end
    endtask

    initial begin
        int len;
        int cnt;
        int first_low;

        tests     = 0;
        fails     = 0;
        reset     = 1'b1;
        ce_pix    = 1'b1;
        hcount    = 10'd0;
        vcount    = 9'd0;
        vblank    = 1'b0;
        dma_done  = 1'b0;
        snd_reply = 1'b0;
        bus.cs    = 1'b0;
        bus.wr    = 1'b0;
        bus.addr  = 2'd0;
        bus.din   = 8'h00;

        // Reset state
        tick();
        tick();
        check("reset_intp", intp, 8'h00);
        reset = 1'b0;
        tick();
        check("post_reset_intp", intp, 8'h00);

        // vblank rising edge with enable=1 -> 16-clk pulse
        cpu_write(2'd2, 8'h01);
        vblank = 1'b1;
        tick();
        check("vblank_first", intp, 8'h01);
        measure(0, len);
        check("vblank_len", len, 16);
        check("vblank_after", intp, 8'h00);

        // vblank edge while ce_pix low is not seen until ce_pix returns
        vblank = 1'b0;
        tick();
        ce_pix = 1'b0;
        vblank = 1'b1;
        tick();
        tick();
        tick();
        check("vblank_no_ce", intp[0], 1'b0);
        ce_pix = 1'b1;
        tick();
        check("vblank_ce_trig", intp[0], 1'b1);
        measure(0, len);
        check("vblank_ce_len", len, 16);

        // Raster compare: line 0x12C = 300 at hcount 320
        cpu_write(2'd0, 8'h2C);
        cpu_write(2'd1, 8'h01);
        cpu_write(2'd2, 8'h04);
        vcount = 9'd300;
        hcount = 10'd319;
        tick();
        check("raster_pre", intp[2], 1'b0);
        hcount = 10'd320;
        tick();
        hcount = 10'd321;
        check("raster_trig", intp, 8'h04);
        measure(2, len);
        check("raster_len", len, 16);
        // Staging a new low byte alone must not move the compare line
        cpu_write(2'd0, 8'h05);
        vcount = 9'd261;
        hcount = 10'd320;
        tick();
        hcount = 10'd321;
        check("raster_staged_only", intp[2], 1'b0);
        vcount = 9'd300;
        hcount = 10'd320;
        tick();
        hcount = 10'd321;
        check("raster_old_line", intp[2], 1'b1);
        measure(2, len);
        check("raster_old_len", len, 16);

        // DMA done twice, 5 clk apart -> 21 clk continuous
        cpu_write(2'd2, 8'h02);
        dma_done = 1'b1;
        tick();
        cnt       = 0;
        first_low = -1;
        for (int k = 0; k < 30; k++) begin
            if (intp[1]) cnt++;
            else if (first_low < 0) first_low = k;
            dma_done = (k == 4);
            tick();
        end
        check("dma_total", cnt, 21);
        check("dma_first_low", first_low, 21);

        // Disable on the same edge as a new vblank trigger
        cpu_write(2'd2, 8'h01);
        vblank = 1'b0;
        tick();
        vblank = 1'b1;
        tick();
        check("dis_pulse_on", intp[0], 1'b1);
        vblank = 1'b0;
        tick();
        vblank = 1'b1;
        cpu_write(2'd2, 8'h00);
        check("dis_next", intp[0], 1'b0);
        cnt = 0;
        for (int k = 0; k < 20; k++) begin
            if (intp[0]) cnt++;
            tick();
        end
        check("dis_stays_low", cnt, 0);

        // Enabling while dma_done is already high: no false trigger
        dma_done = 1'b1;
        tick();
        cpu_write(2'd2, 8'h02);
        tick();
        tick();
        check("dma_mid_level", intp[1], 1'b0);
        dma_done = 1'b0;
        tick();

        // Sound reply level and clear-all priority
        cpu_write(2'd2, 8'h0F);
        snd_reply = 1'b1;
        tick();
        check("snd_level", intp, 8'h08);
        dma_done = 1'b1;
        tick();
        check("snd_dma_on", intp, 8'h0A);
        dma_done = 1'b0;
        tick();
        dma_done = 1'b1;
        cpu_write(2'd3, 8'h00);
        check("clear_prio", intp, 8'h08);
        dma_done = 1'b0;
        tick();
        tick();
        check("clear_snd_held", intp, 8'h08);
        cpu_write(2'd2, 8'h07);
        check("snd_gated", intp[3], 1'b0);
        cpu_write(2'd2, 8'h0F);
        check("snd_regated", intp[3], 1'b1);
        snd_reply = 1'b0;
        #1;
        check("snd_drop", intp[3], 1'b0);

        // Async reset mid-pulse, then vblank already high at release
        vblank = 1'b0;
        tick();
        vblank = 1'b1;
        tick();
        tick();
        tick();
        check("rst_pulse_on", intp[0], 1'b1);
        #3;
        reset = 1'b1;
        #1;
        check("rst_async", intp, 8'h00);
        ce_pix = 1'b0;
        tick();
        tick();
        check("rst_held", intp, 8'h00);
        reset = 1'b0;
        tick();
        check("rst_not_restored", intp, 8'h00);
        cpu_write(2'd2, 8'h01);
        check("rst_wait_ce", intp[0], 1'b0);
        ce_pix = 1'b1;
        tick();
        check("rst_first_ce", intp[0], 1'b1);
        measure(0, len);
        check("rst_first_len", len, 16);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Absolute guard so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout tests=%0d", tests);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/m107_irq_gen.md
M107_IRQ_GEN -- requirements
Module: m107_irq_gen

Interface
REQ-001 SHALL have parameter PULSE_LEN, default 16: clk cycles each edge-type interrupt output is held high (legal range 1..255).
REQ-002 SHALL have parameter RASTER_HPOS, default 10'd320: horizontal count at which the raster compare is evaluated.
REQ-003 SHALL have port clk  input  1: system clock; all state advances on its rising edge.
REQ-004 SHALL have port reset  input  1: asynchronous, active-high reset.
REQ-005 SHALL have port ce_pix  input  1: pixel clock enable, qualifies video-timing sampling.
REQ-006 SHALL have port hcount  input  10: current horizontal pixel count.
REQ-007 SHALL have port vcount  input  9: current line count.
REQ-008 SHALL have port vblank  input  1: vertical blank level from video timing.
REQ-009 SHALL have port cs  input  1: CPU chip select for this block.
REQ-010 SHALL have port wr  input  1: CPU write strobe, one clk wide, qualified by cs.
REQ-011 SHALL have port addr  input  2: register select.
REQ-012 SHALL have port din  input  8: CPU write data.
REQ-013 SHALL have port dma_done  input  1: sprite DMA completion level.
REQ-014 SHALL have port snd_reply  input  1: sound CPU reply-latch pending level.
REQ-015 SHALL have port intp  output  8: interrupt request lines to the interrupt controller.

Function
REQ-016 SHALL map intp: bit0 vblank, bit1 sprite DMA done, bit2 raster compare, bit3 sound reply, bits 7:4 constant 0.
REQ-017 SHALL decode writes (cs & wr): addr0 -> raster_lo staging byte; addr1 -> raster_line <= {din[0], raster_lo}; addr2 -> enable[3:0] <= din[3:0]; addr3 -> clear all active pulses.
REQ-018 SHALL not change raster_line on an addr0 write; only an addr1 write commits it, both bytes at once.
REQ-019 SHALL detect the vblank trigger on a ce_pix cycle where vblank = 1 and the vblank sample from the previous ce_pix cycle = 0.
REQ-020 SHALL detect the raster trigger on a ce_pix cycle where hcount == RASTER_HPOS and vcount == raster_line; a raster_line that is never reached produces no trigger.
REQ-021 SHALL detect the DMA trigger on any clk cycle where dma_done = 1 and dma_done on the previous clk = 0, independent of ce_pix.
REQ-022 SHALL drive intp[3] = snd_reply & enable[3] combinationally from registered inputs, with no stretching.
REQ-023 SHALL give each edge source (bits 0..2) an 8-bit down-counter: a trigger with its enable bit set loads PULSE_LEN; the output bit is 1 while the counter is nonzero; the counter decrements by 1 per clk.
REQ-024 SHALL make the output bit high from the clk edge after the trigger, for exactly PULSE_LEN clk cycles.
REQ-025 SHALL reload the counter to PULSE_LEN when a trigger arrives while a pulse is active (retrigger extends the pulse), with no low gap.
REQ-026 SHALL ignore a trigger whose enable bit is 0; the edge is not remembered.
REQ-027 SHALL zero the counter when its enable bit is written to 0, so the output is low from the next edge; if a trigger occurs on the same edge, the disable takes priority.
REQ-028 SHALL give an addr3 clear priority over a simultaneous trigger (counters become 0), and SHALL not affect intp[3].
REQ-029 SHALL keep the edge-history registers for vblank and dma_done updating whether or not the source is enabled, so enabling mid-level causes no false trigger.

Reset
REQ-030 SHALL, while reset is high, force intp = 8'h00, all counters = 0, enable = 4'h0, raster_line = 9'h000, raster_lo = 8'h00, and edge history = 0.
REQ-031 SHALL abort any active pulse on reset assertion mid-pulse; after release the output is not restored.
REQ-032 SHALL start the first vblank detection after reset from history 0, so a vblank level already high at release triggers on the first ce_pix.

Verification
REQ-033 SHALL cover: enable=4'h1, vblank rises on ce_pix at edge N -> intp[0] = 1 for clk N+1..N+16, then 0.
REQ-034 SHALL cover: write addr0=8'h2C, then addr1=8'h01, then enable=4'h4; the frame reaches vcount=300, hcount=320 -> single intp[2] pulse of 16 clk; an addr0 write alone leaves the old compare line active.
REQ-035 SHALL cover: enable=4'h2, dma_done rises twice 5 clk apart -> intp[1] high continuously for 5+16 = 21 clk.
REQ-036 SHALL cover: intp[0] active, then write enable=4'h0 on the same edge as a new vblank trigger -> intp[0] = 0 next clk and stays 0.
REQ-037 SHALL cover: enable=4'hF, snd_reply held high -> intp[3] = 1 for the whole level; an addr3 write leaves intp[3] = 1 and clears intp[2:0].
REQ-038 SHALL cover: reset asserted asynchronously mid-pulse -> intp = 8'h00 immediately; with vblank high at release, enable=4'h1 -> pulse on the first ce_pix after enable.
